// File: rtl/saradc_11b_dig_lfsr10_pkg.sv
// Shared constants and state encoding for the x^10 + x^7 + 1 dither sequence checker.
package saradc_11b_dig_lfsr10_pkg;

    localparam int LFSR10_TAP_A = 9;
    localparam int LFSR10_TAP_B = 6;
    localparam int LFSR10_LEN   = 10;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/saradc_11b_dig_lfsr10_chk.sv
// Self-synchronising serial checker for the 1023-bit dither sequence: seeds, verifies,
// locks with a flywheel predictor, then flags/counts errors and drops lock on error bursts.
module saradc_11b_dig_lfsr10_chk
    import saradc_11b_dig_lfsr10_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 64,
    parameter int ERR_THR  = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             nres,
    input  logic             data_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int WCNT_W  = $clog2(WIN);
    localparam int WECNT_W = $clog2(ERR_THR + 1);

    localparam logic [3:0]         FCNT_LAST = 4'(LFSR10_LEN - 1);
    localparam logic [7:0]         MCNT_LAST = 8'(LOCK_CNT - 1);
    localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(WIN - 1);
    localparam logic [WECNT_W-1:0] WE_THR    = WECNT_W'(ERR_THR);

    chk_state_t                state_reg, state_next;
    logic [LFSR10_LEN-1:0]     sh_reg, sh_next;
    logic [3:0]                fcnt_reg, fcnt_next;
    logic [7:0]                mcnt_reg, mcnt_next;
    logic [WCNT_W-1:0]         wcnt_reg, wcnt_next;
    logic [WECNT_W-1:0]        wecnt_reg, wecnt_next;
    logic                      err_reg, err_next;
    logic [CNT_W-1:0]          err_cnt_reg, err_cnt_next;

    logic                      pred;
    logic                      mis;
    logic [LFSR10_LEN-1:0]     shifted;
    logic [WECNT_W-1:0]        wecnt_upd;

    assign pred      = sh_reg[LFSR10_TAP_A] ^ sh_reg[LFSR10_TAP_B];
    assign mis       = data_i ^ pred;
    assign shifted   = {sh_reg[LFSR10_LEN-2:0], data_i};
    assign wecnt_upd = wecnt_reg + WECNT_W'(mis);

    always_comb begin
        state_next   = state_reg;
        sh_next      = sh_reg;
        fcnt_next    = fcnt_reg;
        mcnt_next    = mcnt_reg;
        wcnt_next    = wcnt_reg;
        wecnt_next   = wecnt_reg;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;

        if (valid_i) begin
            case (state_reg)
                SEED: begin
                    sh_next = shifted;
                    if (fcnt_reg == FCNT_LAST) begin
                        state_next = VERIFY;
                        fcnt_next  = '0;
                        mcnt_next  = '0;
                    end else begin
                        fcnt_next = fcnt_reg + 4'd1;
                    end
                end
                VERIFY: begin
                    sh_next = shifted;
                    // An all-zero window is the lock-up state of the generator, never real data.
                    if (mis || (shifted == '0)) begin
                        mcnt_next = '0;
                    end else if (mcnt_reg == MCNT_LAST) begin
                        state_next = LOCKED;
                        mcnt_next  = '0;
                        wcnt_next  = '0;
                        wecnt_next = '0;
                    end else begin
                        mcnt_next = mcnt_reg + 8'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: feed back our own prediction so bad input bits cannot poison history.
                    sh_next  = {sh_reg[LFSR10_LEN-2:0], pred};
                    err_next = mis;
                    if (mis && (err_cnt_reg != '1)) begin
                        err_cnt_next = err_cnt_reg + CNT_W'(1);
                    end
                    if (wecnt_upd >= WE_THR) begin
                        state_next = SEED;
                        fcnt_next  = '0;
                        wcnt_next  = '0;
                        wecnt_next = '0;
                    end else if (wcnt_reg == WCNT_LAST) begin
                        wcnt_next  = '0;
                        wecnt_next = '0;
                    end else begin
                        wcnt_next  = wcnt_reg + WCNT_W'(1);
                        wecnt_next = wecnt_upd;
                    end
                end
                default: begin
                    state_next = SEED;
                    fcnt_next  = '0;
                end
            endcase
        end

        if (clear_i) begin
            err_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_reg   <= SEED;
            sh_reg      <= '0;
            fcnt_reg    <= '0;
            mcnt_reg    <= '0;
            wcnt_reg    <= '0;
            wecnt_reg   <= '0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            sh_reg      <= sh_next;
            fcnt_reg    <= fcnt_next;
            mcnt_reg    <= mcnt_next;
            wcnt_reg    <= wcnt_next;
            wecnt_reg   <= wecnt_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign locked_o  = (state_reg == LOCKED);
    assign err_o     = err_reg;
    assign err_cnt_o = err_cnt_reg;

endmodule

// File: tb/tb_saradc_11b_dig_lfsr10_chk.sv
// Directed bench: a reference x^10 + x^7 + 1 generator feeds the checker, with planted errors.
module tb_saradc_11b_dig_lfsr10_chk;

    logic        clk = 1'b0;
    logic        nres, data, valid, clear;
    logic        locked, err;
    logic [15:0] cnt;

    logic        s_data, s_valid, s_clear;
    logic        s_locked, s_err;
    logic [3:0]  s_cnt;

    logic [9:0]  gen;
    int          vectors = 0;
    int          miscompares = 0;
    int          err_seen, lock_seen, pos, lost, nvalid;

    always #5 clk = ~clk;

    saradc_11b_dig_lfsr10_chk dut (
        .clk       (clk),
        .nres      (nres),
        .data_i    (data),
        .valid_i   (valid),
        .clear_i   (clear),
        .locked_o  (locked),
        .err_o     (err),
        .err_cnt_o (cnt)
    );

    saradc_11b_dig_lfsr10_chk #(.LOCK_CNT(16), .WIN(64), .ERR_THR(64), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .nres      (nres),
        .data_i    (s_data),
        .valid_i   (s_valid),
        .clear_i   (s_clear),
        .locked_o  (s_locked),
        .err_o     (s_err),
        .err_cnt_o (s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic d, input logic v, input logic clr);
        @(negedge clk);
        data  = d;
        valid = v;
        clear = clr;
        @(posedge clk);
        #1;
        if (err)    err_seen++;
        if (locked) lock_seen++;
        valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic send(input logic flip, input logic clr);
        logic b;
        b   = gen[9];
        gen = {gen[8:0], gen[9] ^ gen[6]};
        pos++;
        drive(b ^ flip, 1'b1, clr);
    endtask

    task automatic send_sat(input logic flip);
        @(negedge clk);
        s_data  = gen[9] ^ flip;
        s_valid = 1'b1;
        gen     = {gen[8:0], gen[9] ^ gen[6]};
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nres = 1'b0;
        @(negedge clk);
        nres = 1'b1;
    endtask

    initial begin
        nres = 1'b0; data = 1'b0; valid = 1'b0; clear = 1'b0;
        s_data = 1'b0; s_valid = 1'b0; s_clear = 1'b0;
        gen = 10'h3FF; err_seen = 0; lock_seen = 0; pos = 0; lost = 0; nvalid = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_cnt", cnt, 0);
        @(negedge clk);
        nres = 1'b1;

        // Lock from reset: 10 seed + 16 verify bits.
        repeat (25) send(1'b0, 1'b0);
        check("lock_25", locked, 0);
        send(1'b0, 1'b0);
        check("lock_26", locked, 1);
        err_seen = 0; pos = 0;
        repeat (2020) send(1'b0, 1'b0);
        check("clean_errs", err_seen, 0);
        check("clean_cnt", cnt, 0);
        check("clean_locked", locked, 1);

        // Single inverted bit.
        err_seen = 0;
        repeat (99) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("single_pulse", err, 1);
        check("single_cnt", cnt, 1);
        send(1'b0, 1'b0);
        check("single_pulse_end", err, 0);
        repeat (200) send(1'b0, 1'b0);
        check("single_errs", err_seen, 1);
        check("single_cnt2", cnt, 1);
        check("single_locked", locked, 1);

        // Loss of lock: 8 errors inside one aligned window.
        drive(1'b0, 1'b0, 1'b1);
        check("clear_cnt", cnt, 0);
        check("clear_keeps_lock", locked, 1);
        while (pos % 64 != 0) send(1'b0, 1'b0);
        err_seen = 0;
        for (int b = 0; b < 36; b++) begin
            send(b % 5 == 0, 1'b0);
            if (b == 30) check("loss_pre_locked", locked, 1);
        end
        check("loss_err", err, 1);
        check("loss_locked", locked, 0);
        check("loss_cnt", cnt, 8);
        check("loss_errs", err_seen, 8);

        err_seen = 0;
        repeat (25) send(1'b0, 1'b0);
        check("relock_25", locked, 0);
        send(1'b0, 1'b0);
        check("relock_26", locked, 1);
        check("relock_errs", err_seen, 0);
        pos = 0;

        // Seven errors per window for four windows keeps lock.
        drive(1'b0, 1'b0, 1'b1);
        err_seen = 0;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 64; b++) begin
                send((b % 8 == 0) && (b < 56), 1'b0);
                if (!locked) lost++;
            end
        end
        check("w7_lost", lost, 0);
        check("w7_cnt", cnt, 28);
        check("w7_errs", err_seen, 28);

        // clear_i coincident with an error wins over the increment.
        send(1'b1, 1'b1);
        check("clr_err_pulse", err, 1);
        check("clr_err_cnt", cnt, 0);

        // Asynchronous reset while LOCKED with err_o high.
        send(1'b1, 1'b0);
        check("pre_rst_cnt", cnt, 1);
        #2 nres = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_err", err, 0);
        check("arst_cnt", cnt, 0);
        @(posedge clk);
        @(negedge clk);
        nres = 1'b1;
        repeat (25) send(1'b0, 1'b0);
        check("arst_relock_25", locked, 0);
        send(1'b0, 1'b0);
        check("arst_relock_26", locked, 1);

        // Stuck-at inputs never lock.
        do_reset();
        lock_seen = 0;
        repeat (3000) drive(1'b0, 1'b1, 1'b0);
        check("stuck0_lock", lock_seen, 0);
        check("stuck0_cnt", cnt, 0);
        do_reset();
        lock_seen = 0;
        repeat (1200) drive(1'b1, 1'b1, 1'b0);
        check("stuck1_lock", lock_seen, 0);
        check("stuck1_cnt", cnt, 0);

        // Random valid gaps: lock timing counts valid bits only.
        do_reset();
        gen = 10'h3FF;
        nvalid = 0;
        while (nvalid < 25) begin
            if ($urandom_range(0, 1) == 1) begin
                send(1'b0, 1'b0);
                nvalid++;
            end else begin
                drive(1'b0, 1'b0, 1'b0);
            end
        end
        check("gap_25", locked, 0);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        check("gap_idle", locked, 0);
        send(1'b0, 1'b0);
        check("gap_26", locked, 1);

        // Saturation on the narrow-counter instance.
        gen = 10'h3FF;
        repeat (26) send_sat(1'b0);
        check("sat_lock", s_locked, 1);
        repeat (20) send_sat(1'b1);
        check("sat_cnt", s_cnt, 15);
        check("sat_locked", s_locked, 1);
        check("sat_err", s_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
